// File: rtl/wb_switch_nslv_pkg.sv
// Shared types and constants for the Wishbone 1-master / N-slave switch.
package wb_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Read data returned when the watchdog fires.
  localparam logic [15:0] ERR_DATA  = 16'hFFFF;
  // IO page (adr[15:8]) of the optional POST register.
  localparam logic [7:0]  POST_PAGE = 8'hF1;
  // Index value meaning "no slave selected".
  localparam int          NO_SLV    = -1;

  // Low bit of slave idx's slice inside a flattened bus of width-wide lanes.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wb_switch_nslv_if.sv
// Bus bundle between the Zet CPU, the switch and its N slaves.
// The switch uses the slave modport; the surrounding system uses master.
interface wb_switch_nslv_if #(
  parameter int NSLV  = 4,
  parameter int DAT_W = 16
);
  logic [19:1]         m_adr_i;
  logic [DAT_W-1:0]    m_dat_i;
  logic [DAT_W-1:0]    m_dat_o;
  logic                m_we_i;
  logic [1:0]          m_sel_i;
  logic                m_tga_i;
  logic                m_stb_i;
  logic                m_cyc_i;
  logic                m_ack_o;
  logic                m_err_o;
  logic                m_tgc_i;
  logic [NSLV-1:0]     s_stb_o;
  logic [NSLV*DAT_W-1:0] s_dat_i;
  logic [NSLV-1:0]     s_ack_i;
  logic [19:1]         s_adr_o;
  logic [DAT_W-1:0]    s_dat_o;
  logic                s_we_o;
  logic [1:0]          s_sel_o;
  logic                s_tga_o;
  logic [7:0]          to_cnt_o;
  logic [15:0]         post_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_tga_i, m_stb_i, m_cyc_i, m_tgc_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_stb_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_tga_o, to_cnt_o, post_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_tga_i, m_stb_i, m_cyc_i, m_tgc_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_stb_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_tga_o, to_cnt_o, post_o
  );
endinterface

// File: rtl/wb_switch_nslv_region_dec.sv
// Combinational priority decoder for one address space (memory or IO).
// The lowest-index slave whose masked base matches wins; a zero mask
// disables that slave in this space.
module wb_region_dec #(
  parameter int              NSLV  = 4,
  parameter int              W     = 8,
  parameter logic            SPACE = 1'b0,
  parameter logic [W*NSLV-1:0] BASE = '0,
  parameter logic [W*NSLV-1:0] MASK = '0
) (
  input  logic            tga,
  input  logic [W-1:0]    field,
  output logic [NSLV-1:0] match,
  output logic            hit
);

  logic found;

  // Walk slaves from index 0 upward so the first match masks later ones.
  always_comb begin
    match = '0;
    found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      logic cond;
      cond = (tga == SPACE) &&
             (MASK[i*W +: W] != '0) &&
             ((field & MASK[i*W +: W]) == (BASE[i*W +: W] & MASK[i*W +: W]));
      match[i] = cond && !found;
      found    = found | cond;
    end
    hit = found;
  end

endmodule

// File: rtl/wb_switch_nslv.sv
// Wishbone 1-master / N-slave switch for the Zet CPU: address decode,
// read-data/ack muxing, bus-timeout watchdog, auto-ack of unmapped IO and
// interrupt-acknowledge vector.
// Optional POST register: define WB_SWITCH_POSTREG_EN.
module wb_switch_nslv
  import wb_switch_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter int                 DAT_W    = 16,
  parameter logic [8*NSLV-1:0]  MEM_BASE = {NSLV{8'h00}},
  parameter logic [8*NSLV-1:0]  MEM_MASK = {NSLV{8'h00}},
  parameter logic [15*NSLV-1:0] IO_BASE  = {NSLV{15'h0}},
  parameter logic [15*NSLV-1:0] IO_MASK  = {NSLV{15'h0}},
  parameter int                 DEF_MEM  = 0,
  parameter int                 TIMEOUT  = 255,
  parameter int                 TO_W     = 8,
  parameter logic [DAT_W-1:0]   INT_VEC  = 16'd9
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wb_switch_nslv_if.slave  bus
);

  state_t            state_r, state_s;
  logic [TO_W-1:0]   cnt_r, cnt_s;
  logic [NSLV-1:0]   sel_r, sel_s;
  logic [NSLV-1:0]   stb_r, stb_s;
  logic              ack_r, ack_s;
  logic              err_r, err_s;
  logic [DAT_W-1:0]  dat_r, dat_s;
  logic [7:0]        to_cnt_r, to_cnt_s;
  logic              cap_s;
  logic [19:1]       s_adr_r;
  logic [DAT_W-1:0]  s_dat_r;
  logic              s_we_r;
  logic [1:0]        s_sel_r;
  logic              s_tga_r;

  logic [NSLV-1:0]   mem_match_s, io_match_s, def_oh_s;
  logic              mem_hit_s, io_hit_s;
  logic              ack_sel_s;
  int                sel_idx_s;
  logic [DAT_W-1:0]  rd_dat_s;
  logic [31:0]       lat_s;
  logic [7:0]        lat_sat_s;

`ifdef WB_SWITCH_POSTREG_EN
  logic [15:0]       post_r, post_s;
  logic              post_hit_s;
  assign post_hit_s = bus.m_tga_i && (bus.m_adr_i[15:8] == POST_PAGE);
`endif

  wb_region_dec #(
    .NSLV(NSLV), .W(8), .SPACE(1'b0), .BASE(MEM_BASE), .MASK(MEM_MASK)
  ) u_mem_dec (
    .tga(bus.m_tga_i), .field(bus.m_adr_i[19:12]), .match(mem_match_s), .hit(mem_hit_s)
  );

  wb_region_dec #(
    .NSLV(NSLV), .W(15), .SPACE(1'b1), .BASE(IO_BASE), .MASK(IO_MASK)
  ) u_io_dec (
    .tga(bus.m_tga_i), .field(bus.m_adr_i[15:1]), .match(io_match_s), .hit(io_hit_s)
  );

  // Read-data mux from the latched slave plus saturated latency of this cycle.
  always_comb begin
    sel_idx_s = NO_SLV;
    for (int i = NSLV - 1; i >= 0; i--) begin
      sel_idx_s = sel_r[i] ? i : sel_idx_s;
    end
    if (sel_idx_s != NO_SLV) begin
      rd_dat_s = bus.s_dat_i[slice_lo(sel_idx_s, DAT_W) +: DAT_W];
    end else begin
      rd_dat_s = '0;
    end
    ack_sel_s = |(bus.s_ack_i & sel_r);
    lat_s     = 32'(cnt_r);
    lat_sat_s = (lat_s > 32'd255) ? 8'hFF : lat_s[7:0];
    def_oh_s  = '0;
    def_oh_s[DEF_MEM] = 1'b1;
  end

  // Next-state and next-output logic of the cycle FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    sel_s    = sel_r;
    stb_s    = '0;
    ack_s    = 1'b0;
    err_s    = 1'b0;
    dat_s    = dat_r;
    to_cnt_s = to_cnt_r;
    cap_s    = 1'b0;
`ifdef WB_SWITCH_POSTREG_EN
    post_s   = post_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.m_stb_i && bus.m_cyc_i) begin
          cap_s = 1'b1;
          cnt_s = '0;
          if (bus.m_tgc_i) begin
            sel_s   = '0;
            dat_s   = INT_VEC;
            ack_s   = 1'b1;
            state_s = ACK;
          end
`ifdef WB_SWITCH_POSTREG_EN
          else if (post_hit_s) begin
            sel_s   = '0;
            ack_s   = 1'b1;
            state_s = ACK;
            if (bus.m_we_i) begin
              post_s = 16'(bus.m_dat_i);
            end else begin
              dat_s = DAT_W'(post_r);
            end
          end
`endif
          else if (bus.m_tga_i) begin
            if (io_hit_s) begin
              sel_s   = io_match_s;
              stb_s   = io_match_s;
              state_s = ACTIVE;
            end else begin
              // Unmapped IO answers by itself with zero data.
              sel_s   = '0;
              dat_s   = '0;
              ack_s   = 1'b1;
              state_s = ACK;
            end
          end else begin
            sel_s   = mem_hit_s ? mem_match_s : def_oh_s;
            stb_s   = mem_hit_s ? mem_match_s : def_oh_s;
            state_s = ACTIVE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (!bus.m_stb_i) begin
          // Master abandoned the cycle: no ack is generated.
          state_s = IDLE;
        end else if (ack_sel_s) begin
          dat_s    = rd_dat_s;
          ack_s    = 1'b1;
          to_cnt_s = (lat_sat_s > to_cnt_r) ? lat_sat_s : to_cnt_r;
          state_s  = ACK;
        end else if (cnt_r == TO_W'(TIMEOUT - 1)) begin
          dat_s   = DAT_W'(ERR_DATA);
          err_s   = 1'b1;
          ack_s   = 1'b1;
          state_s = ACK;
        end else begin
          cnt_s = cnt_r + TO_W'(1);
          stb_s = sel_r;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, output and broadcast registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      sel_r    <= '0;
      stb_r    <= '0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      dat_r    <= '0;
      to_cnt_r <= 8'h00;
      s_adr_r  <= '0;
      s_dat_r  <= '0;
      s_we_r   <= 1'b0;
      s_sel_r  <= 2'b00;
      s_tga_r  <= 1'b0;
`ifdef WB_SWITCH_POSTREG_EN
      post_r   <= 16'h0000;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      sel_r    <= sel_s;
      stb_r    <= stb_s;
      ack_r    <= ack_s;
      err_r    <= err_s;
      dat_r    <= dat_s;
      to_cnt_r <= to_cnt_s;
`ifdef WB_SWITCH_POSTREG_EN
      post_r   <= post_s;
`endif
      if (cap_s) begin
        s_adr_r <= bus.m_adr_i;
        s_dat_r <= bus.m_dat_i;
        s_we_r  <= bus.m_we_i;
        s_sel_r <= bus.m_sel_i;
        s_tga_r <= bus.m_tga_i;
      end
    end
  end

  assign bus.m_dat_o  = dat_r;
  assign bus.m_ack_o  = ack_r;
  assign bus.m_err_o  = err_r;
  assign bus.s_stb_o  = stb_r;
  assign bus.s_adr_o  = s_adr_r;
  assign bus.s_dat_o  = s_dat_r;
  assign bus.s_we_o   = s_we_r;
  assign bus.s_sel_o  = s_sel_r;
  assign bus.s_tga_o  = s_tga_r;
  assign bus.to_cnt_o = to_cnt_r;
`ifdef WB_SWITCH_POSTREG_EN
  assign bus.post_o   = post_r;
`else
  assign bus.post_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_switch_nslv.sv
// Directed bench for wb_switch_nslv: 3 slaves, TIMEOUT 16.
// Slave 0: default memory, IO bytes 0x400-0x4FF. Slave 1: memory page B8.
// Slave 2: IO bytes 0x400-0x7FF (overlaps slave 0).
module tb_wb_switch_nslv;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   lat;

  wb_switch_nslv_if #(.NSLV(3), .DAT_W(16)) bus ();

  wb_switch_nslv #(
    .NSLV(3), .DAT_W(16),
    .MEM_BASE({8'h00, 8'hB8, 8'h00}),
    .MEM_MASK({8'h00, 8'hFF, 8'h00}),
    .IO_BASE ({15'h0200, 15'h0000, 15'h0200}),
    .IO_MASK ({15'h7E00, 15'h0000, 15'h7F80}),
    .DEF_MEM(0), .TIMEOUT(16), .TO_W(8), .INT_VEC(16'd9)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [19:0] a, input logic tga, input logic we,
                     input logic [15:0] d, input logic tgc);
    bus.m_adr_i = a[19:1];
    bus.m_tga_i = tga;
    bus.m_we_i  = we;
    bus.m_dat_i = d;
    bus.m_tgc_i = tgc;
    bus.m_sel_i = 2'b11;
    bus.m_stb_i = 1'b1;
    bus.m_cyc_i = 1'b1;
  endtask

  task automatic idle_bus();
    bus.m_stb_i = 1'b0;
    bus.m_cyc_i = 1'b0;
    bus.m_tgc_i = 1'b0;
    bus.m_we_i  = 1'b0;
    bus.s_ack_i = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    bus.m_adr_i = '0;
    bus.m_dat_i = 16'h0000;
    bus.m_sel_i = 2'b00;
    bus.m_tga_i = 1'b0;
    idle_bus();
    bus.s_dat_i = {16'hBEEF, 16'hA5A5, 16'h1234};
    tick();
    tick();
    chk("rst_ack",    32'(bus.m_ack_o),  32'd0);
    chk("rst_stb",    32'(bus.s_stb_o),  32'd0);
    chk("rst_dat",    32'(bus.m_dat_o),  32'd0);
    chk("rst_err",    32'(bus.m_err_o),  32'd0);
    chk("rst_to_cnt", 32'(bus.to_cnt_o), 32'd0);
    rst = 1'b0;
    tick();

    // Memory read to slave 1, slave acks in cycle 3.
    req(20'hB8000, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t1_stb_c1", 32'(bus.s_stb_o), 32'b010);
    chk("t1_ack_c1", 32'(bus.m_ack_o), 32'd0);
    tick();
    chk("t1_stb_c2", 32'(bus.s_stb_o), 32'b010);
    tick();
    bus.s_ack_i = 3'b010;
    tick();
    chk("t1_ack_c4", 32'(bus.m_ack_o),  32'd1);
    chk("t1_dat",    32'(bus.m_dat_o),  32'hA5A5);
    chk("t1_err",    32'(bus.m_err_o),  32'd0);
    chk("t1_stb_c4", 32'(bus.s_stb_o),  32'b000);
    chk("t1_to_cnt", 32'(bus.to_cnt_o), 32'd2);
    chk("t1_s_adr",  32'(bus.s_adr_o),  32'h5C000);
    idle_bus();
    tick();
    chk("t1_ack_c5", 32'(bus.m_ack_o), 32'd0);

    // Unmatched memory goes to the default slave, zero-wait ack.
    req(20'h12340, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t2_def_stb", 32'(bus.s_stb_o), 32'b001);
    bus.s_ack_i = 3'b001;
    tick();
    chk("t2_ack_c2",  32'(bus.m_ack_o),  32'd1);
    chk("t2_dat",     32'(bus.m_dat_o),  32'h1234);
    chk("t2_to_cnt",  32'(bus.to_cnt_o), 32'd2);
    idle_bus();
    tick();

    // Unmapped IO acks by itself with zero data.
    req(20'h00300, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t2_io_ack", 32'(bus.m_ack_o), 32'd1);
    chk("t2_io_dat", 32'(bus.m_dat_o), 32'd0);
    chk("t2_io_stb", 32'(bus.s_stb_o), 32'd0);
    idle_bus();
    tick();

    // Slave never acks: watchdog fires 16 cycles after the strobe rose.
    req(20'hB8010, 1'b0, 1'b0, 16'h0000, 1'b0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.m_ack_o) begin
        lat = i;
        break;
      end
    end
    chk("t3_ack_cycle", 32'(lat),          32'd17);
    chk("t3_err",       32'(bus.m_err_o),  32'd1);
    chk("t3_dat",       32'(bus.m_dat_o),  32'hFFFF);
    chk("t3_stb",       32'(bus.s_stb_o),  32'd0);
    chk("t3_to_cnt",    32'(bus.to_cnt_o), 32'd2);
    idle_bus();
    tick();

    // Interrupt acknowledge returns the vector without strobing a slave.
    req(20'h00000, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    chk("t4_ack", 32'(bus.m_ack_o), 32'd1);
    chk("t4_dat", 32'(bus.m_dat_o), 32'd9);
    chk("t4_stb", 32'(bus.s_stb_o), 32'd0);
    idle_bus();
    tick();

    // Overlapping IO windows: slave 0 wins; ack on slave 2 line is ignored.
    req(20'h00400, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t5_overlap_stb", 32'(bus.s_stb_o), 32'b001);
    bus.s_ack_i = 3'b100;
    tick();
    chk("t5_stray_ack", 32'(bus.m_ack_o), 32'd0);
    chk("t5_stb_c2",    32'(bus.s_stb_o), 32'b001);
    bus.s_ack_i = 3'b001;
    tick();
    chk("t5_ack", 32'(bus.m_ack_o), 32'd1);
    chk("t5_dat", 32'(bus.m_dat_o), 32'h1234);
    idle_bus();
    tick();

    // IO window unique to slave 2, ack in cycle 4 raises the latency maximum.
    req(20'h00600, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t5_s2_stb", 32'(bus.s_stb_o), 32'b100);
    tick();
    tick();
    tick();
    bus.s_ack_i = 3'b100;
    tick();
    chk("t5_s2_ack",    32'(bus.m_ack_o),  32'd1);
    chk("t5_s2_dat",    32'(bus.m_dat_o),  32'hBEEF);
    chk("t5_s2_to_cnt", 32'(bus.to_cnt_o), 32'd3);
    idle_bus();
    tick();

    // Abort: strobe drops while ACTIVE, no ack, switch is idle again.
    req(20'hB8000, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t5_ab_stb_c1", 32'(bus.s_stb_o), 32'b010);
    idle_bus();
    tick();
    chk("t5_ab_stb_c2", 32'(bus.s_stb_o), 32'd0);
    chk("t5_ab_ack_c2", 32'(bus.m_ack_o), 32'd0);
    tick();
    chk("t5_ab_ack_c3", 32'(bus.m_ack_o), 32'd0);
    req(20'h00000, 1'b0, 1'b0, 16'h0000, 1'b1);
    tick();
    chk("t5_ab_next_ack", 32'(bus.m_ack_o), 32'd1);
    idle_bus();
    tick();

    // Reset pulse while ACTIVE clears outputs without waiting for a clock.
    req(20'hB8000, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t5_rs_stb_pre", 32'(bus.s_stb_o), 32'b010);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rs_stb",    32'(bus.s_stb_o),  32'd0);
    chk("t5_rs_ack",    32'(bus.m_ack_o),  32'd0);
    chk("t5_rs_to_cnt", 32'(bus.to_cnt_o), 32'd0);
    chk("t5_rs_dat",    32'(bus.m_dat_o),  32'd0);
    idle_bus();
    #2;
    rst = 1'b0;
    tick();
    tick();

    // POST register at IO page F1.
    req(20'h0F100, 1'b1, 1'b1, 16'h00C3, 1'b0);
    tick();
    chk("t6_wr_ack", 32'(bus.m_ack_o), 32'd1);
`ifdef WB_SWITCH_POSTREG_EN
    chk("t6_post", 32'(bus.post_o), 32'h00C3);
`else
    chk("t6_post", 32'(bus.post_o), 32'h0000);
`endif
    idle_bus();
    tick();
    req(20'h0F100, 1'b1, 1'b0, 16'h0000, 1'b0);
    tick();
    chk("t6_rd_ack", 32'(bus.m_ack_o), 32'd1);
`ifdef WB_SWITCH_POSTREG_EN
    chk("t6_rd_dat", 32'(bus.m_dat_o), 32'h00C3);
`else
    chk("t6_rd_dat", 32'(bus.m_dat_o), 32'h0000);
`endif
    idle_bus();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
